mux_arb_nx1: RTL and testbench

Parametrised N-to-1 arbitrating multiplexer with a registered output stage and valid/ready handshakes on every channel. Each of `CH` input channels offers a `W`-bit word. Each cycle the block grants at most one requesting channel and captures its word and channel index into an output register. It is the sequential successor to the combinational select-driven mux and sits between several producers and one shared consumer.

---
 rtl/mux_arb_nx1.sv | 122 ++++++++++++
 tb/tb_mux_arb_nx1.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arb_nx1.sv
// mux_arb_nx1 -- N-to-1 arbitrating multiplexer with a registered output stage.
//
// Each cycle at most one requesting input channel is granted. Its word and
// channel index are captured into the output register. Every channel uses a
// valid/ready handshake.
//
// Configuration macro:
//   MUX_ARB_RR_EN  defined   -> round-robin arbitration driven by a priority pointer
//                  undefined -> fixed priority, where the lowest requesting index wins
//
// Parameters:
//   CH  number of input channels (>= 2)
//   W   data width per channel
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_data    CH*W  flattened input words; channel k is in_data[k*W +: W]
//   in_valid   CH    per-channel request
//   in_ready   CH    per-channel accept (combinational, one-hot or zero)
//   out_data   W     registered output word
//   out_sel    SW    registered index of the channel that supplied out_data
//   out_valid  1     output register holds a word
//   out_ready  1     consumer accepts out_data this cycle
module mux_arb_nx1 #(
  parameter int CH = 4,
  parameter int W  = 3,
  localparam int SW = $clog2(CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH*W-1:0] in_data,
  input  logic [CH-1:0]   in_valid,
  output logic [CH-1:0]   in_ready,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_sel,
  output logic            out_valid,
  input  logic            out_ready
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t        state;
  logic          ld;
  logic          found;
  logic [SW-1:0] grant;
  logic [SW-1:0] idx;
  logic [W-1:0]  words [CH];

`ifdef MUX_ARB_RR_EN
  logic [SW-1:0] ptr;
  logic [SW:0]   sum;
`endif

  for (genvar k = 0; k < CH; k++) begin : g_unpack
    assign words[k] = in_data[k*W +: W];
  end

  assign out_valid = (state == FULL);

  // The output register can take a new word when it is empty or being drained.
  assign ld = !out_valid || out_ready;

  // Grant selection. Round-robin searches upward from ptr and wraps modulo CH.
  // Fixed priority keeps the lowest requesting index.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
`ifdef MUX_ARB_RR_EN
    sum   = '0;
    for (int i = 0; i < CH; i++) begin
      sum = {1'b0, ptr} + (SW+1)'(i);
      if (sum >= (SW+1)'(CH)) sum = sum - (SW+1)'(CH);
      idx = sum[SW-1:0];
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
`else
    for (int i = CH-1; i >= 0; i--) begin
      idx = SW'(i);
      if (in_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
`endif
  end

  // The accept is gated by rst so that upstream never sees a transfer while
  // the output register is being cleared.
  always_comb begin
    in_ready = '0;
    if (!rst && ld && found) in_ready = CH'(1) << grant;
  end

  // The output stage state, data and pointer. An edge with ld low holds everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      out_data <= '0;
      out_sel  <= '0;
`ifdef MUX_ARB_RR_EN
      ptr      <= '0;
`endif
    end else if (ld) begin
      if (found) begin
        state    <= FULL;
        out_data <= words[grant];
        out_sel  <= grant;
`ifdef MUX_ARB_RR_EN
        ptr      <= (grant == SW'(CH-1)) ? '0 : grant + 1'b1;
`endif
      end else begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_mux_arb_nx1.sv
// tb_mux_arb_nx1 -- self-checking bench for mux_arb_nx1 with CH=4 and W=3.
// A behavioural model tracks the expected output register. It is compared
// against the DUT on every cycle. Directed literal expectations pin the model.
module tb_mux_arb_nx1;
  localparam int CH = 4;
  localparam int W  = 3;
  localparam logic [11:0] ABCD = {3'b110, 3'b101, 3'b010, 3'b001};

  logic        clk;
  logic        rst;
  logic [11:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [2:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;

  int tests;
  int fails;

  // Model of the output register and the round-robin pointer.
  int m_valid;
  int m_data;
  int m_sel;
  int m_ptr;

  mux_arb_nx1 #(.CH(CH), .W(W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one value against its expectation and counts the comparison.
  task automatic checkVal(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int wordOf(input logic [11:0] d, input int k);
    return int'((d >> (W*k)) & 12'h7);
  endfunction

  // Returns the channel the arbitration rule picks, or -1 when nothing is requested.
  function automatic int modelGrant(input logic [3:0] v);
    int k;
`ifdef MUX_ARB_RR_EN
    for (int i = 0; i < CH; i++) begin
      k = (m_ptr + i) % CH;
      if (v[2'(k)]) return k;
    end
`else
    for (int i = 0; i < CH; i++) begin
      k = i;
      if (v[2'(k)]) return k;
    end
`endif
    return -1;
  endfunction

  task automatic modelReset();
    m_valid = 0;
    m_data  = 0;
    m_sel   = 0;
    m_ptr   = 0;
  endtask

  // Compares all DUT outputs against the model for the inputs now applied.
  task automatic checkOutput();
    int g;
    int ld;
    int expReady;
    ld = (m_valid == 0 || out_ready) ? 1 : 0;
    g  = modelGrant(in_valid);
    expReady = (ld == 1 && g >= 0) ? (1 << g) : 0;
    checkVal("model in_ready", int'(in_ready), expReady);
    checkVal("model out_valid", int'(out_valid), m_valid);
    checkVal("model out_data", int'(out_data), m_data);
    checkVal("model out_sel", int'(out_sel), m_sel);
  endtask

  // Advances the model by one rising edge under the current inputs.
  task automatic modelStep();
    int g;
    g = modelGrant(in_valid);
    if (m_valid == 0 || out_ready) begin
      if (g >= 0) begin
        m_valid = 1;
        m_data  = wordOf(in_data, g);
        m_sel   = g;
        m_ptr   = (g + 1) % CH;
      end else begin
        m_valid = 0;
      end
    end
  endtask

  // Drives one cycle of inputs at the falling edge, checks, then steps the model.
  task automatic applyStimulus(input logic [3:0] v, input logic r, input logic [11:0] d);
    @(negedge clk);
    in_valid  = v;
    out_ready = r;
    in_data   = d;
    #1;
    checkOutput();
    modelStep();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    modelReset();
    rst = 1'b1;
    in_valid = '0;
    out_ready = 1'b0;
    in_data = ABCD;
    repeat (2) @(posedge clk);
    #1;
    checkVal("reset out_valid", int'(out_valid), 0);
    checkVal("reset out_data", int'(out_data), 0);
    checkVal("reset out_sel", int'(out_sel), 0);
    checkVal("reset in_ready", int'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;

    // A single requester on channel 2, then the output drains.
    applyStimulus(4'b0100, 1'b1, ABCD);
    checkVal("single in_ready", int'(in_ready), 4'b0100);
    applyStimulus(4'b0000, 1'b1, ABCD);
    checkVal("single out_data", int'(out_data), 3'b101);
    checkVal("single out_sel", int'(out_sel), 2);
    checkVal("single out_valid", int'(out_valid), 1);
    applyStimulus(4'b0000, 1'b1, ABCD);
    checkVal("single drain out_valid", int'(out_valid), 0);

    // Wrap and skip from ptr 3 with channels 0 and 1 requesting.
    applyStimulus(4'b0011, 1'b1, ABCD);
    checkVal("wrap first grant", int'(in_ready), 4'b0001);
    applyStimulus(4'b0011, 1'b1, ABCD);
    checkVal("wrap out_sel", int'(out_sel), 0);
`ifdef MUX_ARB_RR_EN
    checkVal("wrap second grant", int'(in_ready), 4'b0010);
`else
    checkVal("wrap second grant", int'(in_ready), 4'b0001);
`endif
    applyStimulus(4'b0000, 1'b1, ABCD);

    // Reset asserted mid-stream while the output holds a word.
    applyStimulus(4'b1111, 1'b0, ABCD);
    applyStimulus(4'b1111, 1'b0, ABCD);
    #2;
    rst = 1'b1;
    #1;
    checkVal("midreset out_valid", int'(out_valid), 0);
    checkVal("midreset out_data", int'(out_data), 0);
    checkVal("midreset out_sel", int'(out_sel), 0);
    checkVal("midreset in_ready", int'(in_ready), 0);
    modelReset();
    @(negedge clk);
    in_valid = '0;
    rst = 1'b0;
    applyStimulus(4'b0000, 1'b1, ABCD);
    checkVal("postreset in_ready", int'(in_ready), 0);

    // All channels are requesting and the consumer is always ready.
    applyStimulus(4'b1111, 1'b1, ABCD);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'b1111, 1'b1, ABCD);
`ifdef MUX_ARB_RR_EN
      checkVal("sweep out_sel", int'(out_sel), i % 4);
      checkVal("sweep out_data", int'(out_data), wordOf(ABCD, i % 4));
`else
      checkVal("sweep out_sel", int'(out_sel), 0);
      checkVal("sweep out_data", int'(out_data), 3'b001);
`endif
      checkVal("sweep out_valid", int'(out_valid), 1);
    end

    // Channels 1 and 3 are requesting continuously.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(4'b1010, 1'b1, ABCD);
      if (i > 0) begin
`ifdef MUX_ARB_RR_EN
        checkVal("pair out_sel", int'(out_sel), (i % 2 == 1) ? 1 : 3);
`else
        checkVal("pair out_sel", int'(out_sel), 1);
        checkVal("pair out_data", int'(out_data), 3'b010);
`endif
      end
    end

    // Backpressure while holding a channel-1 word.
    applyStimulus(4'b0010, 1'b1, ABCD);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b1111, 1'b0, ABCD);
      checkVal("bp in_ready", int'(in_ready), 0);
      checkVal("bp out_data", int'(out_data), 3'b010);
      checkVal("bp out_sel", int'(out_sel), 1);
    end
    applyStimulus(4'b1111, 1'b1, ABCD);
`ifdef MUX_ARB_RR_EN
    checkVal("bp release grant", int'(in_ready), 4'b0100);
`else
    checkVal("bp release grant", int'(in_ready), 4'b0001);
`endif

    // Randomized traffic with random backpressure, checked against the model.
    for (int i = 0; i < 500; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7),
                    12'($urandom));
    end
    applyStimulus(4'b0000, 1'b1, ABCD);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
